// File: rtl/h_matrix_feeder.sv
// h_matrix_feeder: holds one 4x4 complex H matrix and replays it row-major to the
// Hq/Dh calculator once per q_index. Optional WAIT watchdog: define H_FEEDER_TIMEOUT_EN.
module h_matrix_feeder #(
    parameter int N              = 32,
    parameter int Q_NUM          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [3:0]          wr_addr,
    input  logic signed [N-1:0] wr_r,
    input  logic signed [N-1:0] wr_i,
    input  logic                run_start,
    output logic                busy,
    output logic                start_new_q,
    output logic [3:0]          q_index,
    output logic                H_in_valid,
    output logic signed [N-1:0] H_in_r,
    output logic signed [N-1:0] H_in_i,
    input  logic                q_calc_done,
    output logic                run_done
`ifdef H_FEEDER_TIMEOUT_EN
    ,
    output logic                timeout_err
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [3:0] Q_LAST    = 4'(Q_NUM - 1);
    localparam logic [3:0] ELEM_LAST = 4'd15;

    state_t              state_q, state_d;
    logic [3:0]          q_cnt_q, q_cnt_d;
    logic [3:0]          elem_cnt_q, elem_cnt_d;
    logic                busy_q, busy_d;
    logic                start_new_q_q, start_new_q_d;
    logic [3:0]          q_index_q, q_index_d;
    logic                h_valid_q, h_valid_d;
    logic signed [N-1:0] h_r_q, h_r_d;
    logic signed [N-1:0] h_i_q, h_i_d;
    logic                run_done_q, run_done_d;

    logic signed [N-1:0] mem_r_q [16];
    logic signed [N-1:0] mem_i_q [16];

`ifdef H_FEEDER_TIMEOUT_EN
    localparam int             WD_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            timeout_err_q, timeout_err_d;
`endif

    // Host writes are gated by the registered busy flag, so a write landing on the
    // same edge as an accepted run_start is still committed before the first read.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            mem_r_q[wr_addr] <= wr_r;
            mem_i_q[wr_addr] <= wr_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        q_cnt_d    = q_cnt_q;
        elem_cnt_d = elem_cnt_q;
`ifdef H_FEEDER_TIMEOUT_EN
        wd_cnt_d      = wd_cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (run_start) begin
                    state_d = S_START;
                    q_cnt_d = 4'd0;
`ifdef H_FEEDER_TIMEOUT_EN
                    timeout_err_d = 1'b0;
`endif
                end
            end
            S_START: begin
                state_d    = S_STREAM;
                elem_cnt_d = 4'd0;
            end
            S_STREAM: begin
                if (elem_cnt_q == ELEM_LAST) begin
                    state_d = S_WAIT;
`ifdef H_FEEDER_TIMEOUT_EN
                    wd_cnt_d = '0;
`endif
                end else begin
                    elem_cnt_d = elem_cnt_q + 4'd1;
                end
            end
            S_WAIT: begin
                // A done arriving on the timeout cycle takes priority over the watchdog.
                if (q_calc_done) begin
                    if (q_cnt_q == Q_LAST) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_START;
                        q_cnt_d = q_cnt_q + 4'd1;
                    end
                end
`ifdef H_FEEDER_TIMEOUT_EN
                else if (wd_cnt_q == WD_LAST) begin
                    state_d       = S_FINISH;
                    timeout_err_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
`endif
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        start_new_q_d = (state_d == S_START);
        q_index_d     = (state_d == S_START) ? q_cnt_d : q_index_q;
        h_valid_d     = (state_d == S_STREAM);
        h_r_d         = h_valid_d ? mem_r_q[elem_cnt_d] : '0;
        h_i_d         = h_valid_d ? mem_i_q[elem_cnt_d] : '0;
        busy_d        = (state_d == S_START) || (state_d == S_STREAM) || (state_d == S_WAIT);
        run_done_d    = (state_d == S_FINISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            q_cnt_q       <= 4'd0;
            elem_cnt_q    <= 4'd0;
            busy_q        <= 1'b0;
            start_new_q_q <= 1'b0;
            q_index_q     <= 4'd0;
            h_valid_q     <= 1'b0;
            h_r_q         <= '0;
            h_i_q         <= '0;
            run_done_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            q_cnt_q       <= q_cnt_d;
            elem_cnt_q    <= elem_cnt_d;
            busy_q        <= busy_d;
            start_new_q_q <= start_new_q_d;
            q_index_q     <= q_index_d;
            h_valid_q     <= h_valid_d;
            h_r_q         <= h_r_d;
            h_i_q         <= h_i_d;
            run_done_q    <= run_done_d;
        end
    end

`ifdef H_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

    assign busy        = busy_q;
    assign start_new_q = start_new_q_q;
    assign q_index     = q_index_q;
    assign H_in_valid  = h_valid_q;
    assign H_in_r      = h_r_q;
    assign H_in_i      = h_i_q;
    assign run_done    = run_done_q;

endmodule

// File: tb/tb_h_matrix_feeder.sv
// Directed bench for h_matrix_feeder: instance a sweeps 16 q values, instance b
// sweeps one q (and carries the short watchdog when H_FEEDER_TIMEOUT_EN is defined).
module tb_h_matrix_feeder;

    localparam int N = 32;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                wr_en = 1'b0;
    logic [3:0]          wr_addr = 4'd0;
    logic signed [N-1:0] wr_r = '0;
    logic signed [N-1:0] wr_i = '0;
    logic                run_start = 1'b0;
    logic                q_calc_done = 1'b0;

    logic                a_busy, a_snq, a_valid, a_done;
    logic [3:0]          a_qidx;
    logic signed [N-1:0] a_r, a_i;
    logic                b_busy, b_snq, b_valid, b_done;
    logic [3:0]          b_qidx;
    logic signed [N-1:0] b_r, b_i;
`ifdef H_FEEDER_TIMEOUT_EN
    logic                a_terr, b_terr;
`endif

    int checks = 0;
    int errors = 0;
    logic signed [N-1:0] exp_r [16];
    logic signed [N-1:0] exp_i [16];

    h_matrix_feeder #(.N(N), .Q_NUM(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_r(wr_r), .wr_i(wr_i), .run_start(run_start), .busy(a_busy),
        .start_new_q(a_snq), .q_index(a_qidx), .H_in_valid(a_valid),
        .H_in_r(a_r), .H_in_i(a_i), .q_calc_done(q_calc_done), .run_done(a_done)
`ifdef H_FEEDER_TIMEOUT_EN
        , .timeout_err(a_terr)
`endif
    );

    h_matrix_feeder #(.N(N), .Q_NUM(1), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_r(wr_r), .wr_i(wr_i), .run_start(run_start), .busy(b_busy),
        .start_new_q(b_snq), .q_index(b_qidx), .H_in_valid(b_valid),
        .H_in_r(b_r), .H_in_i(b_i), .q_calc_done(q_calc_done), .run_done(b_done)
`ifdef H_FEEDER_TIMEOUT_EN
        , .timeout_err(b_terr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_idle_outputs(input string tag);
        chk({tag, "_busy"}, a_busy, 0);
        chk({tag, "_snq"}, a_snq, 0);
        chk({tag, "_valid"}, a_valid, 0);
        chk({tag, "_r"}, a_r, 0);
        chk({tag, "_i"}, a_i, 0);
        chk({tag, "_qidx"}, a_qidx, 0);
        chk({tag, "_done"}, a_done, 0);
    endtask

    // Entered in the cycle where start_new_q for q is expected; returns in the cycle
    // after q_calc_done was sampled (next start pulse or run_done).
    task automatic stream_q(input int q, input bit chk_b, input bit stray_done,
                            input int wait_cycles, input bit inject, input int abort_at);
        chk($sformatf("q%0d_start", q), a_snq, 1);
        chk($sformatf("q%0d_qidx", q), a_qidx, q);
        chk($sformatf("q%0d_busy", q), a_busy, 1);
        if (chk_b) begin
            chk("b_start", b_snq, 1);
            chk("b_busy", b_busy, 1);
        end
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("q%0d_e%0d_valid", q, k), a_valid, 1);
            chk($sformatf("q%0d_e%0d_r", q, k), a_r, exp_r[k]);
            chk($sformatf("q%0d_e%0d_i", q, k), a_i, exp_i[k]);
            chk($sformatf("q%0d_e%0d_snq", q, k), a_snq, 0);
            chk($sformatf("q%0d_e%0d_qidx", q, k), a_qidx, q);
            chk($sformatf("q%0d_e%0d_done", q, k), a_done, 0);
            if (chk_b) begin
                chk($sformatf("b_e%0d_r", k), b_r, exp_r[k]);
                chk($sformatf("b_e%0d_i", k), b_i, exp_i[k]);
            end
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_a_idle_outputs("abort");
                $display("txn q=%0d aborted at element %0d", q, k);
                return;
            end
            q_calc_done = stray_done && (k == 8 || k == 15);
        end
        step();
        q_calc_done = 1'b0;
        for (int w = 0; w < wait_cycles; w++) begin
            chk($sformatf("q%0d_w%0d_valid", q, w), a_valid, 0);
            chk($sformatf("q%0d_w%0d_r", q, w), a_r, 0);
            chk($sformatf("q%0d_w%0d_snq", q, w), a_snq, 0);
            chk($sformatf("q%0d_w%0d_qidx", q, w), a_qidx, q);
            chk($sformatf("q%0d_w%0d_busy", q, w), a_busy, 1);
            chk($sformatf("q%0d_w%0d_done", q, w), a_done, 0);
            if (chk_b) chk("b_wait_valid", b_valid, 0);
            if (inject && w == 2) begin
                wr_en = 1'b1; wr_addr = 4'd5; wr_r = 99; wr_i = 99; run_start = 1'b1;
            end else begin
                wr_en = 1'b0; run_start = 1'b0;
            end
            step();
        end
        wr_en = 1'b0;
        run_start = 1'b0;
        q_calc_done = 1'b1;
        step();
        q_calc_done = 1'b0;
        $display("txn q=%0d streamed 16 elements", q);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) begin
            exp_r[k] = k;
            exp_i[k] = -k;
        end

        // Reset state
        step();
        chk_a_idle_outputs("reset");
        rst_n = 1'b1;

        // Load r=k, i=-k; the last write coincides with run_start
        for (int k = 0; k < 16; k++) begin
            wr_en = 1'b1; wr_addr = 4'(k); wr_r = k; wr_i = -k;
            run_start = (k == 15);
            step();
        end
        wr_en = 1'b0;
        run_start = 1'b0;

        // Single-q sweep on instance b
        stream_q(0, 1'b1, 1'b0, 3, 1'b0, -1);
        chk("b_run_done", b_done, 1);
        chk("b_busy_at_done", b_busy, 0);
        chk("a_next_start", a_snq, 1);
        step();
        chk("b_run_done_pulse", b_done, 0);
        chk("b_idle_valid", b_valid, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;

        // Full 16-q sweep with busy-time write/run_start and stray done pulses
        run_start = 1'b1;
        step();
        run_start = 1'b0;
        for (int q = 0; q < 16; q++) stream_q(q, 1'b0, q == 4, 19, q == 2, -1);
        chk("a_run_done", a_done, 1);
        chk("a_busy_at_done", a_busy, 0);
        chk("a_no_start_after_last", a_snq, 0);
        step();
        chk("a_run_done_pulse", a_done, 0);

        // Idle rewrite of element 5 now takes effect
        wr_en = 1'b1; wr_addr = 4'd5; wr_r = 99; wr_i = 99;
        step();
        wr_en = 1'b0;
        exp_r[5] = 99;
        exp_i[5] = 99;

        // Asynchronous abort at element 7 of q=3, then restart from q_index 0
        run_start = 1'b1;
        step();
        run_start = 1'b0;
        for (int q = 0; q < 3; q++) stream_q(q, 1'b0, 1'b0, 0, 1'b0, -1);
        stream_q(3, 1'b0, 1'b0, 0, 1'b0, 7);
        step();
        chk_a_idle_outputs("in_reset");
        rst_n = 1'b1;
        step();
        chk_a_idle_outputs("after_abort");
        run_start = 1'b1;
        step();
        run_start = 1'b0;
        stream_q(0, 1'b0, 1'b0, 2, 1'b0, -1);
        chk("restart_q1_qidx", a_qidx, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

`ifdef H_FEEDER_TIMEOUT_EN
        // Watchdog: no q_calc_done, instance b times out after 8 WAIT cycles
        run_start = 1'b1;
        step();
        run_start = 1'b0;
        chk("to_start", b_snq, 1);
        for (int k = 0; k < 16; k++) step();
        chk("to_last_valid", b_valid, 1);
        step();
        for (int w = 1; w <= 8; w++) begin
            chk($sformatf("to_w%0d_done", w), b_done, 0);
            chk($sformatf("to_w%0d_err", w), b_terr, 0);
            step();
        end
        chk("to_run_done", b_done, 1);
        chk("to_err_set", b_terr, 1);
        chk("to_busy", b_busy, 0);
        chk("a_no_timeout", a_terr, 0);
        step();
        chk("to_done_pulse", b_done, 0);
        chk("to_err_sticky", b_terr, 1);
        run_start = 1'b1;
        step();
        run_start = 1'b0;
        chk("to_err_cleared", b_terr, 0);
        chk("to_restart", b_snq, 1);
        $display("txn timeout run completed");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/h_matrix_feeder.md
Name: h_matrix_feeder

Overview:
- Transmit-side counterpart of the H-matrix loader in the Hq/Dh calculation path.
- Holds one 4x4 complex H matrix, written by the host into local storage.
- On command, sweeps q_index 0..Q_NUM-1. For each q it issues a start_new_q pulse, streams the 16 H elements row-major on the H_in_* interface, then waits for the calculator's q_calc_done before moving to the next q.

Parameters:
- N, 32, bit width of each real/imag sample.
- Q_NUM, 16, number of q_index values swept per run (1..16).
- TIMEOUT_CYCLES, 1024, maximum wait for q_calc_done (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  host write strobe into H storage.
- wr_addr  in  4  element address = row*4+col.
- wr_r  in  N  signed real part to store.
- wr_i  in  N  signed imaginary part to store.
- run_start  in  1  one-cycle pulse that starts a sweep.
- busy  out  1  high from the cycle after an accepted run_start until run_done.
- start_new_q  out  1  one-cycle pulse per q to the calculator.
- q_index  out  4  current q, held stable from start_new_q until that q's q_calc_done.
- H_in_valid  out  1  element strobe to the calculator.
- H_in_r  out  N  signed real element.
- H_in_i  out  N  signed imaginary element.
- q_calc_done  in  1  calculator finished the current q.
- run_done  out  1  one-cycle pulse when the sweep completes (or is aborted).
- timeout_err  out  1  sticky error flag (present only with TIMEOUT_EN).

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous and active-low.
- Reset clears all outputs to 0, state to IDLE and all counters to 0. Storage contents are not reset.
- Asserting rst_n low mid-sweep aborts immediately. No run_done pulse is issued for an aborted sweep.
- Storage: 16 x (2N) registers. A write is accepted only when busy=0 and wr_en=1. Writes while busy are ignored.
- run_start is accepted only in IDLE; it is ignored while busy.
- A write and run_start in the same cycle: the write is committed first, so the sweep sees the new value.
- States:
  - IDLE: on run_start, go to START with q_cnt=0; busy goes to 1 the next cycle.
  - START: start_new_q=1 for exactly 1 cycle, q_index=q_cnt, elem_cnt=0; go to STREAM.
  - STREAM: H_in_valid=1 for 16 consecutive cycles, no gaps. Element elem_cnt is driven from storage in order (0,0),(0,1),...,(3,3). The first valid occurs in the cycle immediately after start_new_q. After elem_cnt=15, go to WAIT.
  - WAIT: on q_calc_done=1, go to START with q_cnt+1 if q_cnt<Q_NUM-1; otherwise go to FINISH.
  - FINISH: run_done=1 for 1 cycle, busy=0; go to IDLE.
- q_calc_done is ignored outside WAIT, and ignored in the same cycle as the last valid element.
- H_in_r and H_in_i are driven to 0 whenever H_in_valid=0.
- Outputs are registered: start_new_q, H_in_valid and the data change only on clk edges.
- Latency per q: 1 (start) + 16 (stream) + calculator latency + 1 cycle to re-enter START.
- q_cnt wraps only through IDLE; it never exceeds Q_NUM-1.

Optional Feature:
- Macro H_FEEDER_TIMEOUT_EN.
- When defined:
  - A watchdog counts cycles spent in WAIT.
  - If the count reaches TIMEOUT_CYCLES without q_calc_done, the block goes to FINISH (run_done pulses) and sets timeout_err=1.
  - timeout_err stays 1 until the next accepted run_start or reset.
  - q_calc_done arriving in the same cycle as the timeout wins (no error).
- When undefined: no watchdog and no timeout_err port; WAIT waits indefinitely.

Test Plan:
- Write elements k=0..15 with r=k, i=-k; pulse run_start with Q_NUM=1 -> start_new_q at T, H_in_valid at T+1..T+16 with r=0..15, i=0..-15; no further traffic until q_calc_done; run_done pulses 1 cycle after q_calc_done.
- Q_NUM=16, model responds with q_calc_done 20 cycles after the last element -> 16 start_new_q pulses, q_index=0..15 each held stable, 256 valid elements, one run_done, busy high throughout.
- During the sweep, issue wr_en with wr_addr=5, wr_r=99 and a second run_start -> both ignored; the next q still streams the original element 5; after idle, a rewrite to 99 takes effect in the next run.
- q_calc_done pulsed during STREAM and again in WAIT -> only the WAIT pulse advances q; no extra start_new_q.
- Deassert rst_n at element 7 of q=3 -> all outputs read 0 asynchronously, no run_done; a new run_start restarts at q_index=0.
- With H_FEEDER_TIMEOUT_EN and TIMEOUT_CYCLES=8, never assert q_calc_done -> run_done and timeout_err=1 8 cycles into WAIT; next run_start clears timeout_err.
